// File: rtl/ila_dump_ctrl.sv
// ============================================================================
// Module   : ila_dump_ctrl
// Brief    : Drains the ILA sample buffer, index by index and value_select by
//            value_select, into a valid/ready word stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ila_dump_ctrl #(
    parameter int DATA_W   = 32,
    parameter int BUFFER_W = 10,
    parameter int SEL_W    = 2,
    parameter int N_SEL    = 1,
    parameter int READ_LAT = 2
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      cke_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [BUFFER_W-1:0]       samples_i,
    input  logic [DATA_W-1:0]         value_i,
    output logic [BUFFER_W-1:0]       index_o,
    output logic [SEL_W-1:0]          sel_o,
    output logic                      m_valid_o,
    output logic [DATA_W-1:0]         m_data_o,
    output logic                      m_last_o,
    input  logic                      m_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [BUFFER_W+SEL_W-1:0] words_o
);

    localparam int               CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int               WORDS_W  = BUFFER_W + SEL_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_SEL - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BUFFER_W-1:0] n_q, n_d;
    logic [BUFFER_W-1:0] index_q, index_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WORDS_W-1:0]  words_q, words_d;
    logic [BUFFER_W-1:0] idx_last;

    // Only meaningful once n_q is non-zero, which every busy state guarantees.
    assign idx_last = n_q - BUFFER_W'(1);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        index_d = index_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = done_q;
        words_d = words_q;

        if (abort_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        n_d     = samples_i;
                        index_d = '0;
                        sel_d   = '0;
                        words_d = '0;
                        if (samples_i == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_SETUP;
                            done_d  = 1'b0;
                            busy_d  = 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        data_d  = value_i;
                        last_d  = (index_q == idx_last) && (sel_q == SEL_LAST);
                        valid_d = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (m_ready_i) begin
                        words_d = words_q + WORDS_W'(1);
                        valid_d = 1'b0;
                        if (sel_q < SEL_LAST) begin
                            sel_d   = sel_q + SEL_W'(1);
                            state_d = S_SETUP;
                        end else if (index_q < idx_last) begin
                            sel_d   = '0;
                            index_d = index_q + BUFFER_W'(1);
                            state_d = S_SETUP;
                        end else begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            index_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            words_q <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            n_q     <= n_d;
            index_q <= index_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            words_q <= words_d;
        end
    end

    assign index_o   = index_q;
    assign sel_o     = sel_q;
    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;
    assign m_last_o  = last_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign words_o   = words_q;

endmodule

`default_nettype wire
